// File: rtl/r_type_sequencer_pkg.sv
// Shared types and constants for the R-type sequencer.
// State encoding, funct/opcode values, ALU control codes, field split.
package r_type_sequencer_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_t;

  localparam logic [5:0] R_TYPE    = 6'b000000;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_NOR = 6'b100111;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALUC_AND  = 4'b0000;
  localparam logic [3:0] ALUC_OR   = 4'b0001;
  localparam logic [3:0] ALUC_ADD  = 4'b0010;
  localparam logic [3:0] ALUC_SUB  = 4'b0110;
  localparam logic [3:0] ALUC_SLT  = 4'b0111;
  localparam logic [3:0] ALUC_NOR  = 4'b1100;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [5:0] funct;
  } rtype_t;

  function automatic rtype_t split_instr(
    input logic [31:0] w
  );
    rtype_t f;
    f.opcode = w[31:26];
    f.rs     = w[25:21];
    f.rt     = w[20:16];
    f.rd     = w[15:11];
    f.funct  = w[5:0];
    return f;
  endfunction

endpackage

// File: rtl/r_type_sequencer_funct_decode.sv
// Combinational funct/opcode decoder for the R-type sequencer.
// Ports: opcode, funct in; alu_ctrl, illegal, is_arith out.
module r_type_funct_decode
  import r_type_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [3:0] alu_ctrl,
  output logic       illegal,
  output logic       is_arith
);

  logic r_type;

  assign r_type = (opcode == R_TYPE);

  always_comb begin
    alu_ctrl = ALUC_AND;
    illegal  = 1'b1;
    is_arith = 1'b0;
    unique case (1'b1)
      (r_type && funct == FUNCT_ADD): begin
        alu_ctrl = ALUC_ADD;
        illegal  = 1'b0;
        is_arith = 1'b1;
      end
      (r_type && funct == FUNCT_SUB): begin
        alu_ctrl = ALUC_SUB;
        illegal  = 1'b0;
        is_arith = 1'b1;
      end
      (r_type && funct == FUNCT_AND): begin
        alu_ctrl = ALUC_AND;
        illegal  = 1'b0;
      end
      (r_type && funct == FUNCT_OR): begin
        alu_ctrl = ALUC_OR;
        illegal  = 1'b0;
      end
      (r_type && funct == FUNCT_NOR): begin
        alu_ctrl = ALUC_NOR;
        illegal  = 1'b0;
      end
      (r_type && funct == FUNCT_SLT): begin
        alu_ctrl = ALUC_SLT;
        illegal  = 1'b0;
      end
      default: begin
        alu_ctrl = ALUC_AND;
        illegal  = 1'b1;
        is_arith = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/r_type_sequencer.sv
// Multi-cycle R-type sequencer: IDLE -> READ -> EXEC -> WB, one instr at a time.
// Ports: instr valid/ready in, regfile read/write, ALU operands/ctrl, done status, retired count.
module r_type_sequencer
  import r_type_sequencer_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REG_AW      = 5,
  parameter int CNT_W       = 16,
  parameter bit TRAP_ON_OVF = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [REG_AW-1:0] rf_ra1,
  output logic [REG_AW-1:0] rf_ra2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_overflow,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [DATA_W-1:0] rf_wd,
  output logic              done_valid,
  output logic [DATA_W-1:0] done_result,
  output logic              done_ovf,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired_count
);

  state_t state;
  state_t state_nxt;

  rtype_t fields;

  logic [REG_AW-1:0] rs_q;
  logic [REG_AW-1:0] rt_q;
  logic [REG_AW-1:0] rd_q;
  logic [5:0]        funct_q;
  logic [5:0]        opcode_q;

  logic [DATA_W-1:0] result_q;
  logic              ovf_q;
  logic              illegal_q;
  logic              arith_q;

  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic       dec_arith;

  logic accept;
  logic load_ops;
  logic load_res;
  logic retire;
  logic in_wb;
  logic suppress;

  logic unused_shamt;

  assign unused_shamt = ^instr[10:6];

  assign fields = split_instr(instr);

  r_type_funct_decode u_dec (
    .opcode   (opcode_q),
    .funct    (funct_q),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_illegal),
    .is_arith (dec_arith)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Write-back is dropped for illegal ops, writes to $0,
  // and trapped overflow; completion is still reported.
  assign suppress = illegal_q
                  || (rd_q == '0)
                  || (TRAP_ON_OVF && ovf_q);

  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    accept      = 1'b0;
    load_ops    = 1'b0;
    load_res    = 1'b0;
    in_wb       = 1'b0;
    unique case (state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          accept    = 1'b1;
          state_nxt = S_READ;
        end
      end
      S_READ: begin
        load_ops  = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        load_res  = 1'b1;
        state_nxt = S_WB;
      end
      S_WB: begin
        in_wb     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign retire      = in_wb && !illegal_q;
  assign done_valid  = in_wb;
  assign rf_we       = in_wb && !suppress;
  assign done_ovf    = in_wb && ovf_q;
  assign illegal     = in_wb && illegal_q;
  assign done_result = result_q;
  assign rf_wd       = result_q;
  assign rf_wa       = rd_q;
  assign rf_ra1      = rs_q;
  assign rf_ra2      = rt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs_q          <= '0;
      rt_q          <= '0;
      rd_q          <= '0;
      funct_q       <= '0;
      opcode_q      <= '0;
      alu_a         <= '0;
      alu_b         <= '0;
      alu_ctrl      <= ALUC_AND;
      illegal_q     <= 1'b0;
      arith_q       <= 1'b0;
      result_q      <= '0;
      ovf_q         <= 1'b0;
      retired_count <= '0;
    end else begin
      if (accept) begin
        rs_q     <= fields.rs;
        rt_q     <= fields.rt;
        rd_q     <= fields.rd;
        funct_q  <= fields.funct;
        opcode_q <= fields.opcode;
      end
      if (load_ops) begin
        alu_a     <= rf_rd1;
        alu_b     <= rf_rd2;
        alu_ctrl  <= dec_ctrl;
        illegal_q <= dec_illegal;
        arith_q   <= dec_arith;
      end
      // Overflow only has meaning for add/sub.
      if (load_res) begin
        result_q <= alu_result;
        ovf_q    <= alu_overflow && arith_q;
      end
      if (retire) begin
        retired_count <= retired_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_r_type_sequencer.sv
// Directed testbench for r_type_sequencer with a behavioural regfile and ALU.
// Ports: none.
module tb_r_type_sequencer;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [4:0]  rf_ra1;
  logic [4:0]  rf_ra2;
  logic [31:0] rf_rd1;
  logic [31:0] rf_rd2;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_overflow;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        done_valid;
  logic [31:0] done_result;
  logic        done_ovf;
  logic        illegal;
  logic [15:0] retired_count;

  logic [31:0] rf [32];

  int vecs = 0;
  int errs = 0;

  r_type_sequencer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .rf_ra1        (rf_ra1),
    .rf_ra2        (rf_ra2),
    .rf_rd1        (rf_rd1),
    .rf_rd2        (rf_rd2),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_ctrl      (alu_ctrl),
    .alu_result    (alu_result),
    .alu_overflow  (alu_overflow),
    .rf_we         (rf_we),
    .rf_wa         (rf_wa),
    .rf_wd         (rf_wd),
    .done_valid    (done_valid),
    .done_result   (done_result),
    .done_ovf      (done_ovf),
    .illegal       (illegal),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_rd1 = rf[rf_ra1];
  assign rf_rd2 = rf[rf_ra2];

  always @(posedge clk) begin
    if (rf_we) rf[rf_wa] = rf_wd;
  end

  always_comb begin
    alu_result   = 32'h0;
    alu_overflow = 1'b0;
    case (alu_ctrl)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[31] == alu_b[31])
                    && (alu_result[31] != alu_a[31]);
      end
      4'b0110: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[31] != alu_b[31])
                    && (alu_result[31] != alu_a[31]);
      end
      4'b0111: alu_result = {31'h0, $signed(alu_a) < $signed(alu_b)};
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 32'h0;
    endcase
  end

  // Waits for instr_ready, presents w for one accept edge, returns #1 after it.
  task automatic issue(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    while (!instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    vecs++;
    if (instr_ready !== 1'b1) begin
      errs++;
      $display("FAIL issue_timeout instr=%h ready=%b want 1", w, instr_ready);
    end
    instr       = w;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = 32'h0;
    for (int i = 0; i < 32; i++) rf[i] = i;
    repeat (2) @(negedge clk);
    vecs++;
    if ({instr_ready, rf_we, done_valid, done_ovf, illegal} !== 5'b10000) begin
      errs++;
      $display("FAIL reset_ctl got %b want 10000",
               {instr_ready, rf_we, done_valid, done_ovf, illegal});
    end
    vecs++;
    if (retired_count !== 16'd0 || alu_ctrl !== 4'b0000) begin
      errs++;
      $display("FAIL reset_cnt cnt=%0d ctrl=%b want 0/0000",
               retired_count, alu_ctrl);
    end
    vecs++;
    if ({rf_ra1, rf_ra2, rf_wa} !== 15'h0 || rf_wd !== 32'h0
        || alu_a !== 32'h0 || done_result !== 32'h0) begin
      errs++;
      $display("FAIL reset_data ra1=%0d ra2=%0d wa=%0d wd=%h a=%h dr=%h want 0",
               rf_ra1, rf_ra2, rf_wa, rf_wd, alu_a, done_result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_add;
    issue(32'h00221820);
    @(negedge clk);
    vecs++;
    if (instr_ready !== 1'b0 || rf_ra1 !== 5'd1 || rf_ra2 !== 5'd2) begin
      errs++;
      $display("FAIL add_read rdy=%b ra1=%0d ra2=%0d want 0/1/2",
               instr_ready, rf_ra1, rf_ra2);
    end
    @(negedge clk);
    vecs++;
    if (rf_we !== 1'b0 || done_valid !== 1'b0 || alu_ctrl !== 4'b0010) begin
      errs++;
      $display("FAIL add_exec we=%b dv=%b ctrl=%b want 0/0/0010",
               rf_we, done_valid, alu_ctrl);
    end
    @(negedge clk);
    vecs++;
    if ({rf_we, done_valid, done_ovf, illegal} !== 4'b1100
        || rf_wa !== 5'd3 || rf_wd !== 32'd3 || done_result !== 32'd3) begin
      errs++;
      $display("FAIL add_wb we/dv/ov/il=%b wa=%0d wd=%h dr=%h want 1100/3/3/3",
               {rf_we, done_valid, done_ovf, illegal}, rf_wa, rf_wd, done_result);
    end
    @(negedge clk);
    vecs++;
    if (done_valid !== 1'b0 || rf_we !== 1'b0 || retired_count !== 16'd1
        || instr_ready !== 1'b1) begin
      errs++;
      $display("FAIL add_post dv=%b we=%b cnt=%0d rdy=%b want 0/0/1/1",
               done_valid, rf_we, retired_count, instr_ready);
    end
  endtask

  task automatic test_sub;
    issue(32'h00472822);
    repeat (3) @(negedge clk);
    vecs++;
    if (rf_we !== 1'b1 || done_ovf !== 1'b0 || rf_wa !== 5'd5
        || rf_wd !== 32'hFFFFFFFB || done_valid !== 1'b1) begin
      errs++;
      $display("FAIL sub_wb we=%b ov=%b wa=%0d wd=%h dv=%b want 1/0/5/fffffffb/1",
               rf_we, done_ovf, rf_wa, rf_wd, done_valid);
    end
    @(negedge clk);
    vecs++;
    if (rf[5] !== 32'hFFFFFFFB || retired_count !== 16'd2) begin
      errs++;
      $display("FAIL sub_post rf5=%h cnt=%0d want fffffffb/2",
               rf[5], retired_count);
    end
  endtask

  task automatic test_overflow;
    rf[1] = 32'h7FFFFFFF;
    issue(32'h00212020);
    repeat (3) @(negedge clk);
    vecs++;
    if (done_valid !== 1'b1 || done_ovf !== 1'b1 || rf_we !== 1'b0
        || illegal !== 1'b0) begin
      errs++;
      $display("FAIL ovf_wb dv=%b ov=%b we=%b il=%b want 1/1/0/0",
               done_valid, done_ovf, rf_we, illegal);
    end
    @(negedge clk);
    vecs++;
    if (retired_count !== 16'd3 || rf[4] !== 32'd4) begin
      errs++;
      $display("FAIL ovf_post cnt=%0d rf4=%h want 3/4", retired_count, rf[4]);
    end
    rf[1] = 32'd1;
  endtask

  task automatic test_illegal;
    logic [31:0] words [2];
    words[0] = 32'h0022183F;
    words[1] = 32'h20221820;
    for (int k = 0; k < 2; k++) begin
      issue(words[k]);
      repeat (3) @(negedge clk);
      vecs++;
      if (done_valid !== 1'b1 || illegal !== 1'b1 || rf_we !== 1'b0) begin
        errs++;
        $display("FAIL illegal_wb%0d dv=%b il=%b we=%b want 1/1/0",
                 k, done_valid, illegal, rf_we);
      end
      @(negedge clk);
      vecs++;
      if (retired_count !== 16'd3 || illegal !== 1'b0) begin
        errs++;
        $display("FAIL illegal_post%0d cnt=%0d il=%b want 3/0",
                 k, retired_count, illegal);
      end
    end
  endtask

  task automatic test_rd_zero;
    issue(32'h00220020);
    repeat (3) @(negedge clk);
    vecs++;
    if (done_valid !== 1'b1 || rf_we !== 1'b0 || done_result !== 32'd3
        || illegal !== 1'b0) begin
      errs++;
      $display("FAIL rd0_wb dv=%b we=%b dr=%h il=%b want 1/0/3/0",
               done_valid, rf_we, done_result, illegal);
    end
    @(negedge clk);
    vecs++;
    if (retired_count !== 16'd4 || rf[0] !== 32'd0) begin
      errs++;
      $display("FAIL rd0_post cnt=%0d rf0=%h want 4/0", retired_count, rf[0]);
    end
  endtask

  task automatic test_logic_ops;
    logic [31:0] words [4];
    logic [3:0]  ctrls [4];
    logic [4:0]  was   [4];
    logic [31:0] wds   [4];
    words[0] = 32'h00673024; ctrls[0] = 4'b0000; was[0] = 5'd6;  wds[0] = 32'd3;
    words[1] = 32'h00A1402A; ctrls[1] = 4'b0111; was[1] = 5'd8;  wds[1] = 32'd1;
    words[2] = 32'h00004827; ctrls[2] = 4'b1100; was[2] = 5'd9;  wds[2] = 32'hFFFFFFFF;
    words[3] = 32'h00225025; ctrls[3] = 4'b0001; was[3] = 5'd10; wds[3] = 32'd3;
    for (int k = 0; k < 4; k++) begin
      issue(words[k]);
      repeat (3) @(negedge clk);
      vecs++;
      if (alu_ctrl !== ctrls[k] || rf_we !== 1'b1 || rf_wa !== was[k]
          || rf_wd !== wds[k]) begin
        errs++;
        $display("FAIL logic%0d ctrl=%b we=%b wa=%0d wd=%h want %b/1/%0d/%h",
                 k, alu_ctrl, rf_we, rf_wa, rf_wd, ctrls[k], was[k], wds[k]);
      end
      @(negedge clk);
    end
    vecs++;
    if (retired_count !== 16'd8) begin
      errs++;
      $display("FAIL logic_cnt cnt=%0d want 8", retired_count);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] rdy;
    @(negedge clk);
    instr       = 32'h00221820;
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = 32'h00225820;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      rdy[k] = instr_ready;
      if (k == 2) begin
        vecs++;
        if (done_valid !== 1'b1 || rf_wa !== 5'd3) begin
          errs++;
          $display("FAIL b2b_first dv=%b wa=%0d want 1/3", done_valid, rf_wa);
        end
      end
    end
    vecs++;
    if (rdy !== 4'b1000) begin
      errs++;
      $display("FAIL b2b_ready got %b want 1000", rdy);
    end
    @(posedge clk);
    #1 instr_valid = 1'b0;
    repeat (3) @(negedge clk);
    vecs++;
    if (done_valid !== 1'b1 || rf_we !== 1'b1 || rf_wa !== 5'd11
        || rf_wd !== 32'd3) begin
      errs++;
      $display("FAIL b2b_second dv=%b we=%b wa=%0d wd=%h want 1/1/11/3",
               done_valid, rf_we, rf_wa, rf_wd);
    end
    @(negedge clk);
    vecs++;
    if (retired_count !== 16'd10) begin
      errs++;
      $display("FAIL b2b_cnt cnt=%0d want 10", retired_count);
    end
  endtask

  task automatic test_reset_mid;
    logic seen;
    issue(32'h00226020);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if (rf_we !== 1'b0 || done_valid !== 1'b0 || retired_count !== 16'd0
        || instr_ready !== 1'b1) begin
      errs++;
      $display("FAIL rstmid_now we=%b dv=%b cnt=%0d rdy=%b want 0/0/0/1",
               rf_we, done_valid, retired_count, instr_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen  = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (done_valid || rf_we) seen = 1'b1;
    end
    vecs++;
    if (seen !== 1'b0 || rf[12] !== 32'd12 || retired_count !== 16'd0) begin
      errs++;
      $display("FAIL rstmid_after seen=%b rf12=%h cnt=%0d want 0/c/0",
               seen, rf[12], retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_illegal();
    test_rd_zero();
    test_logic_ops();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/r_type_sequencer.md
Name: r_type_sequencer

Overview:
Multi-cycle controller that sequences R-type instructions through the shared 32x32 register file and 32-bit ALU. It accepts 32-bit instruction words over a valid/ready handshake and decodes rs/rt/rd/funct. It then drives register read addresses, latches operands, drives ALU control, and issues a single write-back strobe. It also reports completion status and keeps a retired-instruction count, replacing free-running every-cycle write-back with explicit one-instruction-at-a-time sequencing.

Parameters:
DATA_W, 32, register/ALU data width
REG_AW, 5, register address width (32 registers)
CNT_W, 16, retired-instruction counter width
TRAP_ON_OVF, 1, 1 = signed overflow on add/sub suppresses write-back

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
instr_valid  in  1  instruction word valid
instr_ready  out  1  sequencer can accept an instruction
instr  in  32  R-type instruction word
rf_ra1  out  REG_AW  register read address A (rs)
rf_ra2  out  REG_AW  register read address B (rt)
rf_rd1  in  DATA_W  register read data A (combinational read)
rf_rd2  in  DATA_W  register read data B
alu_a  out  DATA_W  ALU operand A (latched)
alu_b  out  DATA_W  ALU operand B (latched)
alu_ctrl  out  4  ALU control code
alu_result  in  DATA_W  ALU result (combinational)
alu_overflow  in  1  ALU signed overflow
rf_we  out  1  register write enable, one-cycle pulse
rf_wa  out  REG_AW  register write address (rd)
rf_wd  out  DATA_W  register write data
done_valid  out  1  one-cycle completion pulse
done_result  out  DATA_W  ALU result of completed instruction
done_ovf  out  1  completed instruction overflowed
illegal  out  1  completed instruction was illegal; qualified by done_valid
retired_count  out  CNT_W  count of non-illegal completions, wraps

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; instr_ready=1.
  - rf_we, done_valid, done_ovf, illegal = 0.
  - All address/data outputs = 0; alu_ctrl = 0000; retired_count = 0.
  - Reset mid-operation discards the in-flight instruction; rf_we deasserts immediately.
- States: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. On instr_valid&instr_ready at edge T:
  - latch rs=instr[25:21], rt=[20:16], rd=[15:11], funct=[5:0], opcode=[31:26];
  - go to READ.
- READ (T..T+1):
  - rf_ra1=rs, rf_ra2=rt.
  - Decode funct: 100000 add -> 0010, 100010 sub -> 0110, 100100 and -> 0000, 100101 or -> 0001, 100111 nor -> 1100, 101010 slt -> 0111.
  - Illegal if opcode!=0 or funct not listed.
  - At edge T+1: alu_a<=rf_rd1, alu_b<=rf_rd2, alu_ctrl<=code; go to EXEC.
- EXEC: at edge T+2, latch alu_result and alu_overflow (overflow counted only for add/sub); go to WB.
- WB (cycle after edge T+2, one cycle):
  - done_valid=1; done_result=latched result; done_ovf=latched overflow; illegal=latched illegal flag.
  - rf_wa=rd; rf_wd=result.
  - rf_we=1 unless: illegal, or rd==0, or (TRAP_ON_OVF and overflow).
  - retired_count increments at the end of WB if not illegal.
  - Return to IDLE.
- Latency: accept edge T -> write edge T+3. Throughput: one instruction per 4 cycles. instr_ready=0 in READ/EXEC/WB.
- Illegal instruction still traverses all states; done_result is don't-care and is not checked.
- retired_count wraps at 2^CNT_W-1 -> 0.
- instr_valid may drop before acceptance with no effect. instr is sampled only at the accept edge.

Decomposition:
- Shared package holds:
  - state encoding (IDLE, READ, EXEC, WB);
  - funct constants (FUNCT_ADD, FUNCT_SUB, FUNCT_AND, FUNCT_OR, FUNCT_NOR, FUNCT_SLT);
  - ALU control constants (ALUC_AND=0000, ALUC_OR=0001, ALUC_ADD=0010, ALUC_SUB=0110, ALUC_SLT=0111, ALUC_NOR=1100);
  - opcode R_TYPE=000000.
- One sub-module, r_type_funct_decode: combinational funct/opcode -> alu_ctrl, illegal, is_arith.

Test Plan:
- Register file preloaded rf[i]=i; add $3,$1,$2 (0x00221820) accepted at T -> rf_we=1, rf_wa=3, rf_wd=3 at T+3; done_valid one cycle; retired_count=1.
- sub $5,$2,$7 (0x00472822) -> rf_wd=0xFFFFFFFB, done_ovf=0, rf_we=1.
- rf[1]=0x7FFFFFFF; add $4,$1,$1 (0x00212020) -> done_ovf=1, rf_we=0; retired_count still increments.
- funct=0x3F (0x0022183F) and opcode=0x08 (0x20221820) -> illegal=1 with done_valid, rf_we=0, retired_count unchanged; add $0,$1,$2 (0x00220020) -> rf_we=0, done_result=3.
- instr_valid held high with two instructions back-to-back -> second accepted 4 cycles after the first, instr_ready low for 3 cycles in between; rst_n pulsed low during EXEC -> no rf_we, no done_valid, retired_count=0, instr_ready=1 immediately.
